// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
// Optional build macro: AVALON_ARB_FIXED_PRIO_EN (selects fixed M1-over-M0 priority).
package avalon_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Map a one-hot winner onto the state that serves it.
    function automatic arb_state_t grant_to_state(input logic [1:0] g);
        arb_state_t s;
        case (g)
            GRANT_M0: s = GNT0;
            GRANT_M1: s = GNT1;
            default:  s = IDLE;
        endcase
        return s;
    endfunction

    // One-hot owner encoding of a state.
    function automatic logic [1:0] state_to_grant(input arb_state_t s);
        logic [1:0] g;
        case (s)
            GNT0:    g = GRANT_M0;
            GNT1:    g = GRANT_M1;
            default: g = GRANT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/avalon_arb_pick.sv
// Combinational winner selection for the arbiter.
// Optional build macro: AVALON_ARB_FIXED_PRIO_EN (M1 always wins a tie; `last` ignored).
// Default build: round-robin, the master that is not `last` wins a tie.
module avalon_arb_pick
    import avalon_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] win
);

    logic [1:0] win_s;

`ifdef AVALON_ARB_FIXED_PRIO_EN
    logic unused_last_s;
    assign unused_last_s = last;
`endif

    // Pick a one-hot winner; a lone requester always wins.
    always_comb begin
        win_s = GRANT_NONE;
        case ({req1, req0})
            2'b01: win_s = GRANT_M0;
            2'b10: win_s = GRANT_M1;
            2'b11: begin
`ifdef AVALON_ARB_FIXED_PRIO_EN
                win_s = GRANT_M1;
`else
                if (last) begin
                    win_s = GRANT_M0;
                end else begin
                    win_s = GRANT_M1;
                end
`endif
            end
            default: win_s = GRANT_NONE;
        endcase
    end

    assign win = win_s;

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-master (M0 fetch, M1 data) to one-slave Avalon-MM arbiter.
// The grant is held until the slave completes the transfer; the granted
// master's request is forwarded combinationally, the other master is stalled.
// Optional build macro: AVALON_ARB_FIXED_PRIO_EN (fixed priority, M1 over M0);
// default build is round-robin using a last-winner register.
module avalon_bus_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W/8-1:0]   s_byteenable,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    output logic [1:0]            grant,
    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                req0_s, req1_s, done_s, pick_last_s;
    logic [1:0]          win_s;
    logic [ADDR_W-1:0]   s_address_s;
    logic [BE_W-1:0]     s_byteenable_s;
    logic                s_read_s, s_write_s;
    logic [DATA_W-1:0]   s_writedata_s;
    logic                m0_wait_s, m1_wait_s;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;
    assign done_s = (s_read_s | s_write_s) & ~s_waitrequest;

`ifdef AVALON_ARB_FIXED_PRIO_EN
    // Fixed priority needs no history.
    assign pick_last_s = 1'b1;
`else
    logic last_q, last_d;

    // The finishing owner becomes the last winner.
    always_comb begin
        last_d = last_q;
        if (done_s && (state_q == GNT0)) begin
            last_d = 1'b0;
        end else if (done_s && (state_q == GNT1)) begin
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end
    end

    // Last-winner register; M0 wins the first tie out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // While granted, the policy sees the current owner as last, so a
    // handover on completion favours the other master.
    assign pick_last_s = (state_q == GNT0) ? 1'b0 :
                         ((state_q == GNT1) ? 1'b1 : last_q);
`endif

    avalon_arb_pick u_pick (
        .req0 (req0_s),
        .req1 (req1_s),
        .last (pick_last_s),
        .win  (win_s)
    );

    // Next owner: arbitrate from idle, hand over on completion, drop on abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = grant_to_state(win_s);
            GNT0: begin
                if (done_s) begin
                    state_d = grant_to_state(win_s);
                end else if (!req0_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GNT0;
                end
            end
            GNT1: begin
                if (done_s) begin
                    state_d = grant_to_state(win_s);
                end else if (!req1_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GNT1;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = state_to_grant(state_d);
        busy_d  = (state_d != IDLE);
    end

    // Owner FSM with registered grant/busy; reset drops the grant at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    // Forward the owner's request to the slave and stall everyone else.
    always_comb begin
        s_address_s    = {ADDR_W{1'b0}};
        s_byteenable_s = {BE_W{1'b0}};
        s_read_s       = 1'b0;
        s_write_s      = 1'b0;
        s_writedata_s  = {DATA_W{1'b0}};
        m0_wait_s      = 1'b1;
        m1_wait_s      = 1'b1;
        case (state_q)
            GNT0: begin
                s_address_s    = m0_address;
                s_byteenable_s = m0_byteenable;
                s_read_s       = m0_read;
                s_write_s      = m0_write;
                s_writedata_s  = m0_writedata;
                m0_wait_s      = s_waitrequest;
            end
            GNT1: begin
                s_address_s    = m1_address;
                s_byteenable_s = m1_byteenable;
                s_read_s       = m1_read;
                s_write_s      = m1_write;
                s_writedata_s  = m1_writedata;
                m1_wait_s      = s_waitrequest;
            end
            IDLE: begin
                m0_wait_s = 1'b1;
                m1_wait_s = 1'b1;
            end
            default: begin
                m0_wait_s = 1'b1;
                m1_wait_s = 1'b1;
            end
        endcase
    end

    assign s_address      = s_address_s;
    assign s_byteenable   = s_byteenable_s;
    assign s_read         = s_read_s;
    assign s_write        = s_write_s;
    assign s_writedata    = s_writedata_s;
    assign m0_waitrequest = m0_wait_s;
    assign m1_waitrequest = m1_wait_s;
    assign m0_readdata    = s_readdata;
    assign m1_readdata    = s_readdata;
    assign grant          = grant_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter: directed scenarios followed by
// randomized master traffic, all compared against a cycle-level owner model.
// Optional build macro: AVALON_ARB_FIXED_PRIO_EN (expectations follow it).
module tb_avalon_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] m_addr [2];
    logic [BW-1:0] m_be   [2];
    logic          m_rd   [2];
    logic          m_wr   [2];
    logic [DW-1:0] m_wd   [2];

    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic [AW-1:0] s_address;
    logic [BW-1:0] s_byteenable;
    logic          s_read, s_write, s_waitrequest;
    logic [DW-1:0] s_writedata, s_readdata;
    logic [1:0]    grant;
    logic          busy;

    avalon_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m_addr[0]),
        .m0_byteenable  (m_be[0]),
        .m0_read        (m_rd[0]),
        .m0_write       (m_wr[0]),
        .m0_writedata   (m_wd[0]),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_address     (m_addr[1]),
        .m1_byteenable  (m_be[1]),
        .m1_read        (m_rd[1]),
        .m1_write       (m_wr[1]),
        .m1_writedata   (m_wd[1]),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .s_address      (s_address),
        .s_byteenable   (s_byteenable),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .grant          (grant),
        .busy           (busy)
    );

    // Slave model: stalls each access for slave_delay cycles.
    int slave_delay = 2;
    int wait_cnt;
    assign s_waitrequest = (wait_cnt < slave_delay);
    assign s_readdata    = (s_address == 32'hBFC0_0000) ? 32'h2402_0005 : (s_address ^ 32'h5A5A_A5A5);

    always @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt <= 0;
        else if ((s_read | s_write) && s_waitrequest) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Reference model: owner is -1 (none), 0 (M0) or 1 (M1).
    int own = -1;
    int last_w = 1;
    bit done_m [2];
    bit obs_done [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int arb(input bit r0, input bit r1);
`ifdef AVALON_ARB_FIXED_PRIO_EN
        if (r1) return 1;
        if (r0) return 0;
        return -1;
`else
        if (r0 && r1) return 1 - last_w;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
`endif
    endfunction

    // One clock cycle: check all outputs against the model, then advance it.
    task automatic step(input string tag);
        bit rq [2];
        bit d;
        int nxt;
        logic [1:0] eg; logic [AW-1:0] ea; logic [BW-1:0] ebe;
        logic erd, ewr; logic [DW-1:0] ewd; logic ewq0, ewq1;
        #1;
        rq[0] = m_rd[0] | m_wr[0];
        rq[1] = m_rd[1] | m_wr[1];
        if (own < 0) begin
            eg = 2'b00; ea = '0; ebe = '0; erd = 1'b0; ewr = 1'b0; ewd = '0;
            ewq0 = 1'b1; ewq1 = 1'b1;
        end else begin
            eg = (own == 0) ? 2'b01 : 2'b10;
            ea = m_addr[own]; ebe = m_be[own]; erd = m_rd[own]; ewr = m_wr[own]; ewd = m_wd[own];
            ewq0 = (own == 0) ? s_waitrequest : 1'b1;
            ewq1 = (own == 1) ? s_waitrequest : 1'b1;
        end
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".busy"}, 32'(busy), 32'(own >= 0));
        chk({tag, ".s_addr"}, 32'(s_address), 32'(ea));
        chk({tag, ".s_be"}, 32'(s_byteenable), 32'(ebe));
        chk({tag, ".s_read"}, 32'(s_read), 32'(erd));
        chk({tag, ".s_write"}, 32'(s_write), 32'(ewr));
        chk({tag, ".s_wdata"}, 32'(s_writedata), 32'(ewd));
        chk({tag, ".m0_wait"}, 32'(m0_waitrequest), 32'(ewq0));
        chk({tag, ".m1_wait"}, 32'(m1_waitrequest), 32'(ewq1));
        chk({tag, ".m0_rdata"}, 32'(m0_readdata), 32'(s_readdata));
        chk({tag, ".m1_rdata"}, 32'(m1_readdata), 32'(s_readdata));
        obs_done[0] = rq[0] & ~m0_waitrequest;
        obs_done[1] = rq[1] & ~m1_waitrequest;
        d = (own >= 0) && rq[own] && !s_waitrequest;
        done_m[0] = d && (own == 0);
        done_m[1] = d && (own == 1);
        if (!reset) begin
            nxt = -1; last_w = 1;
        end else if (own < 0) begin
            nxt = arb(rq[0], rq[1]);
        end else if (d) begin
`ifdef AVALON_ARB_FIXED_PRIO_EN
            nxt = arb(rq[0], rq[1]);
`else
            last_w = own;
            if (rq[1 - own]) nxt = 1 - own;
            else if (rq[own]) nxt = own;
            else nxt = -1;
`endif
        end else if (!rq[own]) begin
            nxt = -1;
        end else begin
            nxt = own;
        end
        @(posedge clk);
        own = nxt;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        reset = 1'b0; own = -1; last_w = 1;
        step("rstp");
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, hold, alt_err, prev_own;
        logic [1:0] first_g;
        bit m0_seen, m1_seen;
        bit active [2];
        bit isrd [2];
        for (int x = 0; x < 2; x++) begin
            m_addr[x] = '0; m_be[x] = '0; m_rd[x] = 1'b0; m_wr[x] = 1'b0; m_wd[x] = '0;
            active[x] = 1'b0; isrd[x] = 1'b0;
        end
        reset = 1'b0;
        slave_delay = 2;
        m_rd[0] = 1'b1; m_addr[0] = 32'hBFC0_0000; m_be[0] = 4'hF;
        @(negedge clk);

        // Reset held with M0 requesting, then single read with delay 2.
        step("rst0");
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sread", 32'(s_read), 32'h0);
        step("rst1");
        reset = 1'b1;
        step("rel");
        chk("rel_grant", 32'(grant), 32'h1);
        chk("rd_wait1", 32'(m0_waitrequest), 32'h1);
        step("rd1");
        chk("rd_wait2", 32'(m0_waitrequest), 32'h1);
        step("rd2");
        chk("rd_wait3", 32'(m0_waitrequest), 32'h0);
        chk("rd_data", 32'(m0_readdata), 32'h2402_0005);
        chk("rd_m1wait", 32'(m1_waitrequest), 32'h1);
        step("rd3");
        chk("rd_done", 32'(done_m[0]), 32'h1);
        m_rd[0] = 1'b0;
        step("rdt0"); step("rdt1");

        // Tie from idle: M0 read 0x1000, M1 write 0x2000.
        reset_pulse();
        slave_delay = 1;
        m_rd[0] = 1'b1; m_addr[0] = 32'h0000_1000; m_be[0] = 4'hF;
        m_wr[1] = 1'b1; m_addr[1] = 32'h0000_2000; m_be[1] = 4'hF; m_wd[1] = 32'hDEAD_BEEF;
        first_g = 2'b00; m0_seen = 1'b0; m1_seen = 1'b0;
        for (int i = 0; i < 40 && !(m0_seen && m1_seen); i++) begin
            step("tie");
            if (first_g == 2'b00) first_g = grant;
            if (grant == 2'b10 && s_write && !s_waitrequest) begin
                chk("tie_waddr", 32'(s_address), 32'h0000_2000);
                chk("tie_wdata", 32'(s_writedata), 32'hDEAD_BEEF);
            end
            if (done_m[0]) begin
`ifndef AVALON_ARB_FIXED_PRIO_EN
                chk("tie_handover", 32'(grant), 32'h2);
`endif
                m_rd[0] = 1'b0; m0_seen = 1'b1;
            end
            if (done_m[1]) begin
                m_wr[1] = 1'b0; m1_seen = 1'b1;
            end
        end
`ifdef AVALON_ARB_FIXED_PRIO_EN
        chk("tie_first", 32'(first_g), 32'h2);
`else
        chk("tie_first", 32'(first_g), 32'h1);
`endif
        chk("tie_both_done", 32'(m0_seen && m1_seen), 32'h1);
        m_rd[0] = 1'b0; m_wr[1] = 1'b0;
        step("tie_t0"); step("tie_t1");

        // Fairness: both request continuously for 10 transfers.
        m_rd[0] = 1'b1; m_addr[0] = 32'h0000_3000;
        m_wr[1] = 1'b1; m_addr[1] = 32'h0000_4000; m_wd[1] = 32'h1234_5678;
        c0 = 0; c1 = 0; alt_err = 0; prev_own = -1;
        for (int i = 0; i < 200 && (c0 + c1) < 10; i++) begin
            step("fair");
            if (obs_done[0]) begin
                c0++;
                if (prev_own == 0) alt_err++;
                prev_own = 0;
            end
            if (obs_done[1]) begin
                c1++;
                if (prev_own == 1) alt_err++;
                prev_own = 1;
            end
        end
`ifdef AVALON_ARB_FIXED_PRIO_EN
        chk("fair_c0", 32'(c0), 32'd0);
        chk("fair_c1", 32'(c1), 32'd10);
`else
        chk("fair_c0", 32'(c0), 32'd5);
        chk("fair_c1", 32'(c1), 32'd5);
        chk("fair_alternate", 32'(alt_err), 32'd0);
`endif
        m_rd[0] = 1'b0; m_wr[1] = 1'b0;
        step("fair_t0"); step("fair_t1"); step("fair_t2");

        // Grant stability: M1 requests while M0 waits 4 cycles.
        slave_delay = 4;
        m_rd[0] = 1'b1; m_addr[0] = 32'h0000_5000;
        step("stab0");
        m_wr[1] = 1'b1; m_addr[1] = 32'h0000_6000; m_wd[1] = 32'hCAFE_F00D;
        hold = 0;
        for (int i = 0; i < 20; i++) begin
            step("stab");
            if (done_m[0]) break;
            chk("stab_grant", 32'(grant), 32'h1);
            chk("stab_addr", 32'(s_address), 32'h0000_5000);
            hold++;
        end
        chk("stab_hold", 32'(hold), 32'd4);
        chk("stab_next", 32'(grant), 32'h2);
        m_rd[0] = 1'b0;

        // Async reset between edges while M1 owns the slave.
        chk("ar_pre_write", 32'(s_write), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_swrite", 32'(s_write), 32'h0);
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        own = -1; last_w = 1;
        m_wr[1] = 1'b0;
        @(negedge clk);
        step("ar_rst");
        reset = 1'b1;
        step("ar_rel");

        // Randomized traffic with aborts and varying slave delay.
        for (int c = 0; c < 400; c++) begin
            if (c % 60 == 0) slave_delay = $urandom_range(0, 3);
            for (int x = 0; x < 2; x++) begin
                if (done_m[x]) active[x] = 1'b0;
                if (!active[x]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        active[x] = 1'b1;
                        isrd[x]   = 1'($urandom_range(0, 1));
                        m_addr[x] = $urandom;
                        m_wd[x]   = $urandom;
                        m_be[x]   = 4'($urandom_range(1, 15));
                    end
                end else if ($urandom_range(0, 24) == 0) begin
                    active[x] = 1'b0;
                end
                m_rd[x] = active[x] & isrd[x];
                m_wr[x] = active[x] & ~isrd[x];
            end
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
